// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - digit limits and digit type for the MM:SS stopwatch
package timer_pkg;
   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t SEC_ONES_MAX = 4'd9;
   localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
   localparam bcd_digit_t MIN_ONES_MAX = 4'd9;
   localparam bcd_digit_t MIN_TENS_MAX = 4'd5;
endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one wrapping BCD digit stage of the stopwatch carry chain
module bcd_digit
   import timer_pkg::*;
#(
   parameter bcd_digit_t MAX = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   output bcd_digit_t digit,
   output logic       carry_out
);
   bcd_digit_t r_digit;
   logic       w_at_max;

   // Codes above MAX can only come from corruption; treat them as MAX so they self-clear.
   assign w_at_max  = (r_digit >= MAX);
   assign carry_out = inc & w_at_max;
   assign digit     = r_digit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_digit <= '0;
      end else if (inc) begin
         r_digit <= w_at_max ? bcd_digit_t'(0) : r_digit + 4'd1;
      end
   end
endmodule

// File: rtl/timer.sv
// rtl/timer.sv - MM:SS BCD stopwatch with start/stop toggle on a 1 Hz tick clock
module timer
   import timer_pkg::*;
(
   input  logic        rstn,
   input  logic        actv,
   input  logic        CLK1Hz,
   output logic [15:0] bcd_tim
);
   logic       r_actv_q;
   logic       r_run;
   logic       w_start_toggle;
   logic [2:0] w_carry;
   logic       w_unused_carry;
   bcd_digit_t w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;

   assign w_start_toggle = actv & ~r_actv_q;

   // rstn is active-high despite its name.
   always_ff @(posedge CLK1Hz) begin
      if (rstn) begin
         r_actv_q <= 1'b0;
         r_run    <= 1'b0;
      end else begin
         r_actv_q <= actv;
         if (w_start_toggle) begin
            r_run <= ~r_run;
         end
      end
   end

   // Chain is fed by the pre-edge run value, so the starting edge does not count.
   bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
      .clk(CLK1Hz), .rst(rstn), .inc(r_run),      .digit(w_sec_ones), .carry_out(w_carry[0]));
   bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(CLK1Hz), .rst(rstn), .inc(w_carry[0]), .digit(w_sec_tens), .carry_out(w_carry[1]));
   bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
      .clk(CLK1Hz), .rst(rstn), .inc(w_carry[1]), .digit(w_min_ones), .carry_out(w_carry[2]));
   bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk(CLK1Hz), .rst(rstn), .inc(w_carry[2]), .digit(w_min_tens), .carry_out(w_unused_carry));

   assign bcd_tim = {w_min_tens, w_min_ones, w_sec_tens, w_sec_ones};
endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - randomized and directed self-checking bench for the timer stopwatch
module tb_timer;
   logic        CLK1Hz = 1'b0;
   logic        rstn   = 1'b1;
   logic        actv   = 1'b0;
   logic [15:0] bcd_tim;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   int m_secs = 0;
   bit m_run  = 1'b0;
   bit m_prev = 1'b0;

   timer dut (
      .rstn   (rstn),
      .actv   (actv),
      .CLK1Hz (CLK1Hz),
      .bcd_tim(bcd_tim)
   );

   always #5 CLK1Hz = ~CLK1Hz;

   function automatic logic [15:0] to_bcd(input int secs);
      int mm, ss;
      mm = secs / 60;
      ss = secs % 60;
      to_bcd = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // Elapsed seconds as an integer; the display is derived from it arithmetically.
   always @(posedge CLK1Hz) begin
      if (rstn) begin
         m_secs <= 0;
         m_run  <= 1'b0;
         m_prev <= 1'b0;
      end else begin
         if (m_run) m_secs <= (m_secs + 1) % 3600;
         if (actv && !m_prev) m_run <= !m_run;
         m_prev <= actv;
      end
   end

   always @(negedge CLK1Hz) begin
      if (checking) begin
         n_cmp++;
         if (bcd_tim !== to_bcd(m_secs)) begin
            n_bad++;
            $display("FAIL cycle_cmp t=%0t bcd_tim=%h expected=%h", $time, bcd_tim, to_bcd(m_secs));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK1Hz);
   endtask

   task automatic check_lit(input string nm, input logic [15:0] exp);
      n_cmp++;
      if (bcd_tim !== exp) begin
         n_bad++;
         $display("FAIL %s bcd_tim=%h expected=%h", nm, bcd_tim, exp);
      end
      n_cmp++;
      if (to_bcd(m_secs) !== exp) begin
         n_bad++;
         $display("FAIL model_%s model=%h expected=%h", nm, to_bcd(m_secs), exp);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b1;
      actv = 1'b0;
      step(1);
      rstn = 1'b0;
   endtask

   task automatic pulse();
      actv = 1'b1;
      step(1);
      actv = 1'b0;
   endtask

   initial begin
      step(2);
      checking = 1'b1;
      check_lit("reset_hold", 16'h0000);
      rstn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check_lit("idle_after_reset", 16'h0000);
      end

      // Start latency and the first minute
      pulse();
      check_lit("start_edge_no_inc", 16'h0000);
      step(1);
      check_lit("first_count", 16'h0001);
      step(59);
      check_lit("sixty_edges", 16'h0100);

      // Full hour with carry boundaries
      do_reset();
      pulse();
      step(59);
      check_lit("at_0059", 16'h0059);
      step(1);
      check_lit("carry_0100", 16'h0100);
      step(539);
      check_lit("at_0959", 16'h0959);
      step(1);
      check_lit("carry_1000", 16'h1000);
      step(2999);
      check_lit("at_5959", 16'h5959);
      step(1);
      check_lit("wrap_0000", 16'h0000);
      step(1);
      check_lit("after_wrap", 16'h0001);

      // Pause / resume / held actv
      do_reset();
      pulse();
      step(9);
      check_lit("pause_pre", 16'h0009);
      pulse();
      check_lit("stop_edge_counts", 16'h0010);
      step(20);
      check_lit("paused_hold", 16'h0010);
      pulse();
      check_lit("resume_edge", 16'h0010);
      step(1);
      check_lit("resumed", 16'h0011);
      actv = 1'b1;
      step(10);
      check_lit("held_actv_one_toggle", 16'h0012);
      actv = 1'b0;
      step(3);
      check_lit("held_release", 16'h0012);

      // Mid-run reset
      do_reset();
      pulse();
      step(157);
      check_lit("at_0237", 16'h0237);
      do_reset();
      check_lit("midrun_reset", 16'h0000);
      step(10);
      check_lit("no_count_after_reset", 16'h0000);

      // Randomized start/stop and occasional reset
      for (int i = 0; i < 4000; i++) begin
         actv = ($urandom_range(0, 5) == 0);
         rstn = ($urandom_range(0, 799) == 0);
         step(1);
      end
      rstn = 1'b0;
      actv = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
